// File: rtl/apb_pkg.sv
// Shared APB definitions for the requester (apb_master) and the completer (apb_slave) blocks.
// Holds the default bus widths and the requester state encoding.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_e;

endpackage

// File: rtl/apb_master.sv
// APB3 requester: turns one valid/ready command into a SETUP/ACCESS transfer and returns the
// response (read data, slave error, timeout) on a valid/ready response channel.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic              i_cmd_write,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_slverr,
    output logic              o_rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PSELx,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // A zero timeout still needs a legal one-bit counter even though it never aborts.
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    apb_master_state_e state_q, state_d;

    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rspValid_q, rspValid_d;
    logic [DATA_W-1:0] rspRdata_q, rspRdata_d;
    logic              rspSlverr_q, rspSlverr_d;
    logic              rspTimeout_q, rspTimeout_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspSlverr_q  <= 1'b0;
            rspTimeout_q <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            rspValid_q   <= rspValid_d;
            rspRdata_q   <= rspRdata_d;
            rspSlverr_q  <= rspSlverr_d;
            rspTimeout_q <= rspTimeout_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        rspValid_d   = rspValid_q;
        rspRdata_d   = rspRdata_q;
        rspSlverr_d  = rspSlverr_q;
        rspTimeout_d = rspTimeout_q;
        waitCnt_d    = waitCnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    paddr_d  = i_cmd_addr;
                    pwrite_d = i_cmd_write;
                    pwdata_d = i_cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                waitCnt_d = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rspRdata_d   = pwrite_q ? '0 : PRDATA;
                    rspSlverr_d  = PSLVERR;
                    rspTimeout_d = 1'b0;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rspValid_d   = 1'b1;
                    state_d      = RESP;
                end else if (TIMEOUT_EN && (waitCnt_q == CNT_LAST)) begin
                    // Abort on the last allowed wait cycle so the slave never sees more than TIMEOUT_CYCLES.
                    rspRdata_d   = '0;
                    rspSlverr_d  = 1'b1;
                    rspTimeout_d = 1'b1;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rspValid_d   = 1'b1;
                    state_d      = RESP;
                end else if (waitCnt_q != CNT_MAX) begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_rsp_valid   = rspValid_q;
    assign o_rsp_rdata   = rspRdata_q;
    assign o_rsp_slverr  = rspSlverr_q;
    assign o_rsp_timeout = rspTimeout_q;
    assign PADDR         = paddr_q;
    assign PWRITE        = pwrite_q;
    assign PWDATA        = pwdata_q;
    assign PSELx         = psel_q;
    assign PENABLE       = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: one instance with a 4-cycle timeout, one with the timeout disabled.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetN;
    logic          cmdValid, cmdValidB;
    logic [AW-1:0] cmdAddr;
    logic          cmdWrite;
    logic [DW-1:0] cmdWdata;
    logic          rspReady;
    logic [DW-1:0] prdata;
    logic          pready, preadyB;
    logic          pslverr;

    logic          cmdReady, rspValid, rspSlverr, rspTimeout, pwrite, psel, penable;
    logic [DW-1:0] rspRdata, pwdata;
    logic [AW-1:0] paddr;

    logic          cmdReadyB, rspValidB, rspSlverrB, rspTimeoutB, pwriteB, pselB, penableB;
    logic [DW-1:0] rspRdataB, pwdataB;
    logic [AW-1:0] paddrB;

    int testCount = 0;
    int failCount = 0;
    int accessCount;

    always #5 clk = ~clk;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_reset_n(resetN),
        .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady),
        .i_cmd_addr(cmdAddr), .i_cmd_write(cmdWrite), .i_cmd_wdata(cmdWdata),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
        .o_rsp_rdata(rspRdata), .o_rsp_slverr(rspSlverr), .o_rsp_timeout(rspTimeout),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSELx(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(0)) dutNoTimeout (
        .i_clk(clk), .i_reset_n(resetN),
        .i_cmd_valid(cmdValidB), .o_cmd_ready(cmdReadyB),
        .i_cmd_addr(cmdAddr), .i_cmd_write(cmdWrite), .i_cmd_wdata(cmdWdata),
        .o_rsp_valid(rspValidB), .i_rsp_ready(rspReady),
        .o_rsp_rdata(rspRdataB), .o_rsp_slverr(rspSlverrB), .o_rsp_timeout(rspTimeoutB),
        .PADDR(paddrB), .PWRITE(pwriteB), .PWDATA(pwdataB), .PSELx(pselB), .PENABLE(penableB),
        .PRDATA(prdata), .PREADY(preadyB), .PSLVERR(pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [AW-1:0] addr,
                                 input logic write, input logic [DW-1:0] wdata);
        cmdValid = valid;
        cmdAddr  = addr;
        cmdWrite = write;
        cmdWdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        resetN    = 1'b0;
        cmdValidB = 1'b0;
        rspReady  = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        preadyB   = 1'b0;
        pslverr   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        checkOutput("reset psel", psel, 0);
        checkOutput("reset penable", penable, 0);
        checkOutput("reset rsp_valid", rspValid, 0);
        checkOutput("reset cmd_ready", cmdReady, 1);
        checkOutput("reset paddr", paddr, 0);
        resetN = 1'b1;

        // Zero-wait write
        $display("[TB] write, zero wait");
        pready = 1'b1;
        applyStimulus(1'b1, 32'h4, 1'b1, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("wr setup psel", psel, 1);
        checkOutput("wr setup penable", penable, 0);
        checkOutput("wr setup cmd_ready", cmdReady, 0);
        checkOutput("wr setup paddr", paddr, 32'h4);
        checkOutput("wr setup pwrite", pwrite, 1);
        checkOutput("wr setup pwdata", pwdata, 32'hDEADBEEF);
        tick();
        checkOutput("wr access psel", psel, 1);
        checkOutput("wr access penable", penable, 1);
        tick();
        checkOutput("wr resp psel", psel, 0);
        checkOutput("wr resp penable", penable, 0);
        checkOutput("wr resp valid", rspValid, 1);
        checkOutput("wr resp slverr", rspSlverr, 0);
        checkOutput("wr resp rdata", rspRdata, 0);
        checkOutput("wr resp timeout", rspTimeout, 0);
        checkOutput("wr paddr retained", paddr, 32'h4);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput("wr done valid", rspValid, 0);
        checkOutput("wr done cmd_ready", cmdReady, 1);

        // Read with two wait states
        $display("[TB] read, two wait states");
        pready = 1'b0;
        applyStimulus(1'b1, 32'h8, 1'b0, 32'hFFFF0000);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rd access%0d penable", i), penable, 1);
            checkOutput($sformatf("rd access%0d paddr", i), paddr, 32'h8);
            checkOutput($sformatf("rd access%0d valid", i), rspValid, 0);
        end
        pready = 1'b1;
        prdata = 32'h12345678;
        tick();
        pready = 1'b0;
        checkOutput("rd resp valid", rspValid, 1);
        checkOutput("rd resp rdata", rspRdata, 32'h12345678);
        checkOutput("rd resp slverr", rspSlverr, 0);
        checkOutput("rd resp psel", psel, 0);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;

        // Slave error on a read
        $display("[TB] slave error");
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hCAFE0001;
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("err resp valid", rspValid, 1);
        checkOutput("err resp slverr", rspSlverr, 1);
        checkOutput("err resp timeout", rspTimeout, 0);
        checkOutput("err resp rdata", rspRdata, 32'hCAFE0001);
        pslverr  = 1'b0;
        pready   = 1'b0;
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;

        // Timeout after four ACCESS cycles
        $display("[TB] timeout");
        prdata = 32'hA5A5A5A5;
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        accessCount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (penable) accessCount++;
            if (rspValid) break;
        end
        checkOutput("to access cycles", accessCount, 4);
        checkOutput("to resp valid", rspValid, 1);
        checkOutput("to psel", psel, 0);
        checkOutput("to slverr", rspSlverr, 1);
        checkOutput("to timeout", rspTimeout, 1);
        checkOutput("to rdata", rspRdata, 0);

        // Response backpressure with a pending command
        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h30, 1'b1, 32'h000055AA);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp%0d valid", i), rspValid, 1);
            checkOutput($sformatf("bp%0d timeout", i), rspTimeout, 1);
            checkOutput($sformatf("bp%0d cmd_ready", i), cmdReady, 0);
            checkOutput($sformatf("bp%0d psel", i), psel, 0);
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput("bp release valid", rspValid, 0);
        checkOutput("bp release cmd_ready", cmdReady, 1);
        checkOutput("bp release psel", psel, 0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("bp next psel", psel, 1);
        checkOutput("bp next paddr", paddr, 32'h30);
        checkOutput("bp next pwdata", pwdata, 32'h000055AA);

        // Reset during a wait state
        $display("[TB] reset in access");
        tick();
        tick();
        checkOutput("pre-reset penable", penable, 1);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        checkOutput("rst psel", psel, 0);
        checkOutput("rst penable", penable, 0);
        checkOutput("rst valid", rspValid, 0);
        checkOutput("rst cmd_ready", cmdReady, 1);

        // Timeout disabled: a hung slave keeps the transfer in ACCESS
        $display("[TB] timeout disabled");
        cmdValidB = 1'b1;
        applyStimulus(1'b0, 32'h40, 1'b0, 32'h0);
        tick();
        cmdValidB = 1'b0;
        tick();
        repeat (100) tick();
        checkOutput("nto psel", pselB, 1);
        checkOutput("nto penable", penableB, 1);
        checkOutput("nto valid", rspValidB, 0);
        checkOutput("nto cmd_ready", cmdReadyB, 0);
        checkOutput("nto paddr", paddrB, 32'h40);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
